// File: rtl/fpu_add_sequencer_if.sv
// Control/status bundle between FP issue logic, the adder sequencer and the adder datapath.
// The master side drives the operation inputs and flags; the slave side is the sequencer.
interface fpu_add_sequencer_if #(
  parameter int EXP_W = 8
);
  logic             i_start;
  logic [EXP_W:0]   i_exp_diff;
  logic             i_sum_zero;
  logic             i_sum_ovf;
  logic [4:0]       i_sum_lz;
  logic             i_round_ovf;
  logic [EXP_W-1:0] i_exp_cur;

  logic             o_busy;
  logic             o_done;
  logic             o_ex0_mux_ctrl;
  logic             o_ex1_mux_ctrl;
  logic             o_frac_a_mux_ctrl;
  logic             o_frac_b_mux_ctrl;
  logic [7:0]       o_align_shift;
  logic             o_sum_mux_ctrl;
  logic             o_norm_dir;
  logic [4:0]       o_norm_amt;
  logic             o_exp_incdec;
  logic [4:0]       o_exp_delta;
  logic             o_exp_load;
  logic             o_frac_load;
  logic             o_round_en;
  logic             o_exc_ovf;
  logic             o_exc_zero;

  modport master (
    output i_start, i_exp_diff, i_sum_zero, i_sum_ovf, i_sum_lz, i_round_ovf, i_exp_cur,
    input  o_busy, o_done, o_ex0_mux_ctrl, o_ex1_mux_ctrl, o_frac_a_mux_ctrl,
           o_frac_b_mux_ctrl, o_align_shift, o_sum_mux_ctrl, o_norm_dir, o_norm_amt,
           o_exp_incdec, o_exp_delta, o_exp_load, o_frac_load, o_round_en,
           o_exc_ovf, o_exc_zero
  );

  modport slave (
    input  i_start, i_exp_diff, i_sum_zero, i_sum_ovf, i_sum_lz, i_round_ovf, i_exp_cur,
    output o_busy, o_done, o_ex0_mux_ctrl, o_ex1_mux_ctrl, o_frac_a_mux_ctrl,
           o_frac_b_mux_ctrl, o_align_shift, o_sum_mux_ctrl, o_norm_dir, o_norm_amt,
           o_exp_incdec, o_exp_delta, o_exp_load, o_frac_load, o_round_en,
           o_exc_ovf, o_exc_zero
  );
endinterface

// File: rtl/fpu_add_sequencer.sv
// Multi-cycle controller for the single-precision adder datapath: align, add, normalise,
// round and optional re-normalise, with sticky overflow/zero exception flags.
module fpu_add_sequencer #(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int SHIFT_SAT = FRAC_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  fpu_add_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_RCHK, S_RENORM, S_DONE
  } state_t;

  localparam logic [EXP_W-1:0] EXP_TOP = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W:0]   SAT_VAL = (EXP_W+1)'(SHIFT_SAT);

  state_t           r_state;
  state_t           w_next;
  logic [EXP_W:0]   r_diff;
  logic [EXP_W:0]   w_abs_diff;
  logic             r_exc_ovf;
  logic             r_exc_zero;
  logic             w_set_ovf;
  logic             w_set_zero;
  logic             w_accept;

  assign w_accept   = (r_state == S_IDLE) && bus.i_start;
  // Two's-complement magnitude; -2^EXP_W maps to 2^EXP_W, which still saturates below.
  assign w_abs_diff = r_diff[EXP_W] ? (~r_diff + (EXP_W+1)'(1)) : r_diff;

  assign bus.o_exc_ovf  = r_exc_ovf;
  assign bus.o_exc_zero = r_exc_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_diff     <= '0;
      r_exc_ovf  <= 1'b0;
      r_exc_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_diff     <= bus.i_exp_diff;
        r_exc_ovf  <= 1'b0;
        r_exc_zero <= 1'b0;
      end else begin
        if (w_set_ovf)  r_exc_ovf  <= 1'b1;
        if (w_set_zero) r_exc_zero <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next                = r_state;
    w_set_ovf             = 1'b0;
    w_set_zero            = 1'b0;
    bus.o_busy            = (r_state != S_IDLE) && (r_state != S_DONE);
    bus.o_done            = 1'b0;
    bus.o_ex0_mux_ctrl    = 1'b0;
    bus.o_ex1_mux_ctrl    = 1'b0;
    bus.o_frac_a_mux_ctrl = 1'b0;
    bus.o_frac_b_mux_ctrl = 1'b0;
    bus.o_align_shift     = 8'd0;
    bus.o_sum_mux_ctrl    = 1'b0;
    bus.o_norm_dir        = 1'b0;
    bus.o_norm_amt        = 5'd0;
    bus.o_exp_incdec      = 1'b0;
    bus.o_exp_delta       = 5'd0;
    bus.o_exp_load        = 1'b0;
    bus.o_frac_load       = 1'b0;
    bus.o_round_en        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_next = S_ALIGN;
      end
      S_ALIGN: begin
        bus.o_ex0_mux_ctrl    = r_diff[EXP_W];
        bus.o_frac_a_mux_ctrl = ~r_diff[EXP_W];
        bus.o_frac_b_mux_ctrl = r_diff[EXP_W];
        bus.o_align_shift     = (w_abs_diff >= SAT_VAL) ? 8'(SHIFT_SAT) : 8'(w_abs_diff);
        bus.o_exp_load        = 1'b1;
        w_next                = S_ADD;
      end
      S_ADD: begin
        bus.o_frac_load = 1'b1;
        w_next          = S_NORM;
      end
      S_NORM: begin
        w_next = S_ROUND;
        if (bus.i_sum_zero) begin
          w_set_zero = 1'b1;
          w_next     = S_DONE;
        end else if (bus.i_sum_ovf) begin
          bus.o_norm_dir     = 1'b1;
          bus.o_norm_amt     = 5'd1;
          bus.o_exp_delta    = 5'd1;
          bus.o_ex1_mux_ctrl = 1'b1;
          bus.o_exp_load     = 1'b1;
          w_set_ovf          = (bus.i_exp_cur == EXP_TOP);
        end else if (bus.i_sum_lz != 5'd0) begin
          bus.o_norm_amt   = bus.i_sum_lz;
          bus.o_exp_incdec = 1'b1;
          bus.o_exp_delta  = bus.i_sum_lz;
          // Shifting by at least the exponent would underflow: flush the result to zero.
          if (bus.i_exp_cur <= EXP_W'(bus.i_sum_lz)) begin
            w_set_zero = 1'b1;
            w_next     = S_DONE;
          end
        end
      end
      S_ROUND: begin
        bus.o_round_en     = 1'b1;
        bus.o_sum_mux_ctrl = 1'b1;
        bus.o_frac_load    = 1'b1;
        w_next             = S_RCHK;
      end
      S_RCHK: begin
        w_next = bus.i_round_ovf ? S_RENORM : S_DONE;
      end
      S_RENORM: begin
        bus.o_norm_dir     = 1'b1;
        bus.o_norm_amt     = 5'd1;
        bus.o_exp_delta    = 5'd1;
        bus.o_ex1_mux_ctrl = 1'b1;
        bus.o_exp_load     = 1'b1;
        w_set_ovf          = (bus.i_exp_cur == EXP_TOP);
        w_next             = S_DONE;
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
